// File: rtl/riscv_mon_pkg.sv
// riscv_mon_pkg
//   Shared types and constants for the RISC-V execution monitor.
//   cause_t : reason the monitored program stopped (held in halt_cause)
//   state_t : run-control state of the monitor
//   OP_BRANCH / INSTR_ECALL : encodings the monitor decodes
package riscv_mon_pkg;

    typedef enum logic [2:0] {
        CAUSE_NONE   = 3'd0,
        CAUSE_ECALL  = 3'd1,
        CAUSE_HALTW  = 3'd2,
        CAUSE_BRANCH = 3'd3,
        CAUSE_CYCLE  = 3'd4
    } cause_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [6:0]  OP_BRANCH   = 7'b1100011;
    localparam logic [31:0] INSTR_ECALL = 32'h00000073;

    // B-type instructions share a single major opcode.
    function automatic logic is_branch_op(input logic [6:0] opcode);
        return opcode == OP_BRANCH;
    endfunction

endpackage

// File: rtl/mon_sat_counter.sv
// mon_sat_counter
//   Saturating up-counter used for the cycle, branch and store counts.
//   Ports:
//     clk        in   clock
//     rst        in   synchronous active-high reset
//     clr        in   synchronous clear to zero
//     inc        in   advance by one (held at all-ones once reached)
//     count      out  current count
//     count_plus out  value the counter would take if inc were asserted;
//                     lets the owner evaluate limits on the post-increment
//                     value without a combinational path through inc.
module mon_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic [W-1:0] count_plus
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign count_plus = (&count_q) ? count_q : count_q + {{(W-1){1'b0}}, 1'b1};

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_plus;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/riscv_exec_monitor.sv
// riscv_exec_monitor
//   Run-control monitor for the single-cycle RISC-V core. Watches the
//   retiring instruction stream and store port, counts cycles, branches and
//   stores, and stops the run on ECALL, the halt word, a branch-count limit
//   or a cycle watchdog. The first cause seen is latched in halt_cause.
//   Optional feature macro: MON_STORE_SIG_EN adds store_sig, a rotating
//   XOR signature over (address ^ data) of every counted store.
//   Ports:
//     clk, rst                    clock, synchronous active-high reset
//     start                       IDLE -> RUN (zeroes counters)
//     clear                       HALTED -> IDLE (zeroes counters)
//     instr_valid, instr          retiring instruction
//     mem_write, data_adr,
//     write_data                  store strobe / address / data
//     running, halted             state flags
//     halt_cause                  cause_t of the halt, NONE otherwise
//     cycle_count, branch_count,
//     store_count                 saturating counters, frozen outside RUN
//     store_sig                   (MON_STORE_SIG_EN only) store signature
module riscv_exec_monitor
    import riscv_mon_pkg::*;
#(
    parameter int          XLEN         = 32,
    parameter int          CNT_W        = 16,
    parameter int          BR_W         = 8,
    parameter int          MAX_CYCLES   = 1000,
    parameter int          MAX_BRANCHES = 20,
    parameter logic [31:0] HALT_WORD    = 32'hFFFFFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic             instr_valid,
    input  logic [XLEN-1:0]  instr,
    input  logic             mem_write,
    input  logic [XLEN-1:0]  data_adr,
    input  logic [XLEN-1:0]  write_data,
`ifdef MON_STORE_SIG_EN
    output logic [XLEN-1:0]  store_sig,
`endif
    output logic             running,
    output logic             halted,
    output logic [2:0]       halt_cause,
    output logic [CNT_W-1:0] cycle_count,
    output logic [BR_W-1:0]  branch_count,
    output logic [CNT_W-1:0] store_count
);

    localparam logic [CNT_W-1:0] MAX_CYC_L = CNT_W'(MAX_CYCLES);
    localparam logic [BR_W-1:0]  MAX_BR_L  = BR_W'(MAX_BRANCHES);

    state_t state_q, state_d;
    cause_t cause_q, cause_d;
    cause_t hit_cause;

    logic             cnt_clr;
    logic             count_en;
    logic             instr_is_branch;
    logic [CNT_W-1:0] cyc_plus;
    logic [BR_W-1:0]  br_plus;
    logic [CNT_W-1:0] st_plus;
    logic [BR_W-1:0]  br_post;

    assign instr_is_branch = is_branch_op(instr[6:0]);

    mon_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr        (cnt_clr),
        .inc        (count_en),
        .count      (cycle_count),
        .count_plus (cyc_plus)
    );

    mon_sat_counter #(.W(BR_W)) u_branch_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr        (cnt_clr),
        .inc        (count_en & instr_is_branch),
        .count      (branch_count),
        .count_plus (br_plus)
    );

    mon_sat_counter #(.W(CNT_W)) u_store_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr        (cnt_clr),
        .inc        (count_en & mem_write),
        .count      (store_count),
        .count_plus (st_plus)
    );

    // Limits compare against the value the counters will hold after this
    // instruction is counted, so the triggering instruction is included.
    assign br_post = instr_is_branch ? br_plus : branch_count;

    always_comb begin
        hit_cause = CAUSE_NONE;
        if (instr == XLEN'(INSTR_ECALL)) begin
            hit_cause = CAUSE_ECALL;
        end else if (instr == XLEN'(HALT_WORD)) begin
            hit_cause = CAUSE_HALTW;
        end else if (br_post > MAX_BR_L) begin
            hit_cause = CAUSE_BRANCH;
        end else if (cyc_plus == MAX_CYC_L) begin
            hit_cause = CAUSE_CYCLE;
        end
    end

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        cnt_clr  = 1'b0;
        count_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cnt_clr = 1'b1;
                    cause_d = CAUSE_NONE;
                end
            end
            ST_RUN: begin
                if (instr_valid) begin
                    count_en = 1'b1;
                    if (hit_cause != CAUSE_NONE) begin
                        state_d = ST_HALTED;
                        cause_d = hit_cause;
                    end
                end
            end
            ST_HALTED: begin
                if (clear) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                    cause_d = CAUSE_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cause_d = CAUSE_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

`ifdef MON_STORE_SIG_EN
    logic [XLEN-1:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (state_q == ST_IDLE && start) begin
            sig_d = '0;
        end else if (count_en && mem_write) begin
            sig_d = {sig_q[XLEN-2:0], sig_q[XLEN-1]} ^ data_adr ^ write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign store_sig = sig_q;
`else
    // Store address/data only feed the signature.
    logic unused_store_bus;
    assign unused_store_bus = ^{data_adr, write_data};
`endif

    // Store counter's look-ahead value has no limit attached.
    logic unused_st_plus;
    assign unused_st_plus = ^st_plus;

    assign running    = (state_q == ST_RUN);
    assign halted     = (state_q == ST_HALTED);
    assign halt_cause = cause_q;

endmodule

// File: tb/tb_riscv_exec_monitor.sv
// Directed bench for riscv_exec_monitor. u_dut uses default parameters;
// u_dut2 uses tiny counters, MAX_BRANCHES=0, MAX_CYCLES=3 and a halt word
// that is itself a branch, so cause priority can be exercised directly.
module tb_riscv_exec_monitor;

    localparam logic [31:0] NOP    = 32'h00000013;
    localparam logic [31:0] ECALL  = 32'h00000073;
    localparam logic [31:0] BRANCH = 32'h00000063;
    localparam logic [31:0] HALTW  = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic        start2 = 1'b0;
    logic        clear2 = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        mem_write = 1'b0;
    logic [31:0] data_adr = 32'h0;
    logic [31:0] write_data = 32'h0;

    logic        running, halted, running2, halted2;
    logic [2:0]  halt_cause, halt_cause2;
    logic [15:0] cycle_count, store_count;
    logic [7:0]  branch_count;
    logic [1:0]  cycle_count2, store_count2, branch_count2;
`ifdef MON_STORE_SIG_EN
    logic [31:0] store_sig, store_sig2;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    riscv_exec_monitor u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .clear        (clear),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .mem_write    (mem_write),
        .data_adr     (data_adr),
        .write_data   (write_data),
`ifdef MON_STORE_SIG_EN
        .store_sig    (store_sig),
`endif
        .running      (running),
        .halted       (halted),
        .halt_cause   (halt_cause),
        .cycle_count  (cycle_count),
        .branch_count (branch_count),
        .store_count  (store_count)
    );

    riscv_exec_monitor #(
        .CNT_W        (2),
        .BR_W         (2),
        .MAX_CYCLES   (3),
        .MAX_BRANCHES (0),
        .HALT_WORD    (32'h00000063)
    ) u_dut2 (
        .clk          (clk),
        .rst          (rst),
        .start        (start2),
        .clear        (clear2),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .mem_write    (mem_write),
        .data_adr     (data_adr),
        .write_data   (write_data),
`ifdef MON_STORE_SIG_EN
        .store_sig    (store_sig2),
`endif
        .running      (running2),
        .halted       (halted2),
        .halt_cause   (halt_cause2),
        .cycle_count  (cycle_count2),
        .branch_count (branch_count2),
        .store_count  (store_count2)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, act);
        end
    endtask

    // One clock with the given instruction-bus values; sample 1ns after edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic mw,
                        input logic [31:0] adr, input logic [31:0] wd);
        instr_valid = v;
        instr       = ins;
        mem_write   = mw;
        data_adr    = adr;
        write_data  = wd;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        mem_write   = 1'b0;
    endtask

    task automatic pulse(input int which);
        case (which)
            0: start  = 1'b1;
            1: clear  = 1'b1;
            2: start2 = 1'b1;
            default: clear2 = 1'b1;
        endcase
        @(posedge clk);
        #1;
        start = 1'b0; clear = 1'b0; start2 = 1'b0; clear2 = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_running", {31'b0, running}, 32'd0);
        check_eq("rst_halted",  {31'b0, halted}, 32'd0);
        check_eq("rst_cause",   {29'b0, halt_cause}, 32'd0);
        check_eq("rst_cycles",  {16'b0, cycle_count}, 32'd0);

        // 1: four NOPs then ECALL
        pulse(0);
        check_eq("t1_running", {31'b0, running}, 32'd1);
        for (int i = 0; i < 4; i++) step(1'b1, NOP, 1'b0, 32'h0, 32'h0);
        check_eq("t1_pre_halt", {31'b0, halted}, 32'd0);
        step(1'b1, ECALL, 1'b0, 32'h0, 32'h0);
        check_eq("t1_halted",   {31'b0, halted}, 32'd1);
        check_eq("t1_cause",    {29'b0, halt_cause}, 32'd1);
        check_eq("t1_cycles",   {16'b0, cycle_count}, 32'd5);
        check_eq("t1_branches", {24'b0, branch_count}, 32'd0);
        pulse(0);
        check_eq("t1_start_ignored", {31'b0, halted}, 32'd1);
        pulse(1);
        check_eq("t1_clear_idle",   {30'b0, running, halted}, 32'd0);
        check_eq("t1_clear_cause",  {29'b0, halt_cause}, 32'd0);
        check_eq("t1_clear_cycles", {16'b0, cycle_count}, 32'd0);

        // 2: branch loop, halt on the 21st branch
        pulse(0);
        for (int i = 0; i < 20; i++) step(1'b1, BRANCH, 1'b0, 32'h0, 32'h0);
        check_eq("t2_run_at_20", {31'b0, running}, 32'd1);
        check_eq("t2_br_at_20",  {24'b0, branch_count}, 32'd20);
        pulse(1);
        check_eq("t2_clear_ignored", {31'b0, running}, 32'd1);
        step(1'b0, ECALL, 1'b0, 32'h0, 32'h0);
        check_eq("t2_invalid_no_halt", {31'b0, running}, 32'd1);
        check_eq("t2_invalid_no_count", {16'b0, cycle_count}, 32'd20);
        step(1'b1, BRANCH, 1'b0, 32'h0, 32'h0);
        check_eq("t2_halted",   {31'b0, halted}, 32'd1);
        check_eq("t2_cause",    {29'b0, halt_cause}, 32'd3);
        check_eq("t2_branches", {24'b0, branch_count}, 32'd21);
        check_eq("t2_cycles",   {16'b0, cycle_count}, 32'd21);
        pulse(1);

        // 3: cycle watchdog at 1000
        pulse(0);
        for (int i = 0; i < 999; i++) step(1'b1, NOP, 1'b0, 32'h0, 32'h0);
        check_eq("t3_run_at_999", {31'b0, running}, 32'd1);
        step(1'b1, NOP, 1'b0, 32'h0, 32'h0);
        check_eq("t3_halted", {31'b0, halted}, 32'd1);
        check_eq("t3_cause",  {29'b0, halt_cause}, 32'd4);
        check_eq("t3_cycles", {16'b0, cycle_count}, 32'd1000);
        for (int i = 0; i < 5; i++) step(1'b1, NOP, 1'b0, 32'h0, 32'h0);
        check_eq("t3_frozen", {16'b0, cycle_count}, 32'd1000);
        pulse(1);

        // 4: halt word on default instance, then priority on u_dut2
        pulse(0);
        step(1'b1, BRANCH, 1'b0, 32'h0, 32'h0);
        step(1'b1, HALTW, 1'b0, 32'h0, 32'h0);
        check_eq("t4_haltw_cause",    {29'b0, halt_cause}, 32'd2);
        check_eq("t4_haltw_branches", {24'b0, branch_count}, 32'd1);
        pulse(1);
        pulse(2);
        step(1'b1, BRANCH, 1'b0, 32'h0, 32'h0);
        check_eq("t4_prio_halted", {31'b0, halted2}, 32'd1);
        check_eq("t4_prio_haltw",  {29'b0, halt_cause2}, 32'd2);
        check_eq("t4_prio_br",     {30'b0, branch_count2}, 32'd1);
        pulse(3);
        pulse(2);
        step(1'b1, NOP, 1'b1, 32'h0, 32'h0);
        step(1'b1, NOP, 1'b1, 32'h0, 32'h0);
        step(1'b1, ECALL, 1'b1, 32'h0, 32'h0);
        check_eq("t4_prio_ecall",  {29'b0, halt_cause2}, 32'd1);
        check_eq("t4_ecall_cyc",   {30'b0, cycle_count2}, 32'd3);
        check_eq("t4_ecall_st",    {30'b0, store_count2}, 32'd3);
        pulse(3);
        pulse(2);
        for (int i = 0; i < 3; i++) step(1'b1, NOP, 1'b0, 32'h0, 32'h0);
        check_eq("t4_small_cycle", {29'b0, halt_cause2}, 32'd4);
        pulse(3);

        // 5: reset mid-run with stores
        pulse(0);
        for (int i = 0; i < 10; i++) step(1'b1, NOP, 1'b1, 32'h100 + i, i);
        check_eq("t5_stores", {16'b0, store_count}, 32'd10);
        check_eq("t5_cycles", {16'b0, cycle_count}, 32'd10);
        rst = 1'b1;
        step(1'b1, NOP, 1'b1, 32'h200, 32'h1);
        rst = 1'b0;
        check_eq("t5_rst_state",  {30'b0, running, halted}, 32'd0);
        check_eq("t5_rst_cycles", {16'b0, cycle_count}, 32'd0);
        check_eq("t5_rst_stores", {16'b0, store_count}, 32'd0);
        check_eq("t5_rst_cause",  {29'b0, halt_cause}, 32'd0);
        pulse(0);
        check_eq("t5_restart", {31'b0, running}, 32'd1);
        step(1'b1, NOP, 1'b0, 32'h0, 32'h0);
        check_eq("t5_restart_cyc", {16'b0, cycle_count}, 32'd1);

`ifdef MON_STORE_SIG_EN
        // 6: store signature
        step(1'b1, NOP, 1'b1, 32'h64, 32'h7);
        check_eq("t6_sig1", store_sig, 32'h00000063);
        step(1'b1, NOP, 1'b1, 32'h64, 32'h19);
        check_eq("t6_sig2", store_sig, 32'h000000BB);
        check_eq("t6_stores", {16'b0, store_count}, 32'd2);
        step(1'b1, ECALL, 1'b0, 32'h0, 32'h0);
        pulse(1);
        pulse(0);
        check_eq("t6_sig_restart", store_sig, 32'h0);
`else
        step(1'b1, ECALL, 1'b0, 32'h0, 32'h0);
        check_eq("t6_final_cause", {29'b0, halt_cause}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
